load_store_unit: RTL

Data-memory interface stage sitting directly downstream of the core's `control` sequencer. It latches the effective address, store data and `funct3` in the `EXECUTE` state and drives the byte-lane-masked memory request during `BYTE`. For loads, it captures and sign/zero-extends the read data at the end of `WAIT_LOADING`. It also flags misaligned or illegal-width accesses and suppresses them.

---
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Data-memory interface stage that follows the core's control sequencer.
// An access is accepted in EXECUTE. Its byte-lane-masked request is driven
// during BYTE. A load result is extended and registered at the end of
// WAIT_LOADING and flagged with a one-cycle load_valid pulse in the next cycle.
// Misaligned or illegal-width accesses are suppressed and raise a sticky flag.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   state           control sequencer state (EXECUTE=4, BYTE=5, WAIT_LOADING=6)
//   isLtype/isStype decoded load/store class (sampled in EXECUTE)
//   funct3          access width/sign (sampled in EXECUTE)
//   alu_addr        effective byte address (sampled in EXECUTE)
//   rs2_data        store source (sampled in EXECUTE)
//   mem_addr        word-aligned request address
//   mem_wdata       lane-replicated store data
//   mem_wmask       byte write enables, live only in the BYTE cycle
//   mem_rstrb       read strobe, live only in the BYTE cycle
//   mem_rdata       read word, valid during WAIT_LOADING
//   load_data       extended load result
//   load_valid      one-cycle pulse after load_data updates
//   misaligned      sticky fault flag, cleared only by reset
//   fsm_state       debug view of the internal FSM (IDLE=0, ISSUE=1, CAPTURE=2)
//
// Handshake: there is no back-pressure. The unit follows the control
// sequencer cycle by cycle. A request is presented for exactly one cycle
// (BYTE), and the memory always completes it at the closing edge.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        state,
    input  logic              isLtype,
    input  logic              isStype,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [31:0]       rs2_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misaligned,
    output logic [1:0]        fsm_state
);

    localparam logic [3:0] ST_EXECUTE      = 4'd4;
    localparam logic [3:0] ST_BYTE         = 4'd5;
    localparam logic [3:0] ST_WAIT_LOADING = 4'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic              op_load_q, op_load_d;
    logic              bad_q, bad_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        byte_off_q, byte_off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic              rstrb_q, rstrb_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              mis_q, mis_d;

    logic        accept;
    logic        misalign_now;
    logic        illegal_now;
    logic [1:0]  off_now;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    logic [31:0] rd_lane;

    always_comb begin
        off_now = alu_addr[1:0];
        accept  = (fsm_q == IDLE) && (state == ST_EXECUTE) && (isLtype || isStype);

        misalign_now = ((funct3[1:0] == 2'b01) && off_now[0]) ||
                       ((funct3[1:0] == 2'b10) && (off_now != 2'b00));
        // A load class wins if both decode flags are ever raised together.
        if (isLtype) begin
            illegal_now = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end else begin
            illegal_now = (funct3 >= 3'd3);
        end

        case (funct3[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << off_now;
                lane_data = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << off_now;
                lane_data = {2{rs2_data[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = rs2_data;
            end
        endcase

        rd_lane = mem_rdata >> {byte_off_q, 3'b000};

        fsm_d        = fsm_q;
        op_load_d    = op_load_q;
        bad_d        = bad_q;
        funct3_d     = funct3_q;
        byte_off_d   = byte_off_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = 4'b0000;
        rstrb_d      = 1'b0;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        mis_d        = mis_q;

        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    op_load_d  = isLtype;
                    bad_d      = misalign_now || illegal_now;
                    funct3_d   = funct3;
                    byte_off_d = off_now;
                    addr_d     = {alu_addr[ADDR_W-1:2], 2'b00};
                    if (!isLtype) begin
                        wdata_d = lane_data;
                    end
                    if (misalign_now || illegal_now) begin
                        mis_d = 1'b1;
                    end else if (isLtype) begin
                        rstrb_d = 1'b1;
                    end else begin
                        wmask_d = lane_mask;
                    end
                    fsm_d = ISSUE;
                end
            end
            ISSUE: begin
                // Any state other than BYTE aborts the access.
                fsm_d = (state == ST_BYTE) ? CAPTURE : IDLE;
            end
            CAPTURE: begin
                fsm_d = IDLE;
                if ((state == ST_WAIT_LOADING) && op_load_q && !bad_q) begin
                    case (funct3_q)
                        3'd0:    load_data_d = {{24{rd_lane[7]}}, rd_lane[7:0]};
                        3'd4:    load_data_d = {24'd0, rd_lane[7:0]};
                        3'd1:    load_data_d = {{16{rd_lane[15]}}, rd_lane[15:0]};
                        3'd5:    load_data_d = {16'd0, rd_lane[15:0]};
                        default: load_data_d = rd_lane;
                    endcase
                    load_valid_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= IDLE;
            op_load_q    <= 1'b0;
            bad_q        <= 1'b0;
            funct3_q     <= 3'd0;
            byte_off_q   <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            wmask_q      <= 4'd0;
            rstrb_q      <= 1'b0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            op_load_q    <= op_load_d;
            bad_q        <= bad_d;
            funct3_q     <= funct3_d;
            byte_off_q   <= byte_off_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            rstrb_q      <= rstrb_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            mis_q        <= mis_d;
        end
    end

    // The strobes are also gated by the live state. If control leaves BYTE
    // early, the request is dropped in that same cycle.
    always_comb begin
        mem_wmask = ((fsm_q == ISSUE) && (state == ST_BYTE)) ? wmask_q : 4'b0000;
        mem_rstrb = (fsm_q == ISSUE) && (state == ST_BYTE) && rstrb_q;
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misaligned = mis_q;
    assign fsm_state  = fsm_q;

endmodule
